// File: rtl/stream_delay_multi.sv
// Multi-channel valid/ready delay line.
// Each channel is an in-order FIFO with a per-entry release countdown.
module stream_delay_multi #(
  parameter int unsigned NumChan   = 5,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Depth     = 8,
  parameter int unsigned CntWidth  = 8,
  parameter bit          JitterEn  = 1'b0,
  parameter logic [15:0] LfsrSeed  = 16'hACE1,
  localparam int unsigned OccW     = $clog2(Depth + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumChan*CntWidth-1:0]   delay_i,
  input  logic [CntWidth-1:0]           jitter_mask_i,
  input  logic [NumChan-1:0]            valid_i,
  output logic [NumChan-1:0]            ready_o,
  input  logic [NumChan*DataWidth-1:0]  data_i,
  output logic [NumChan-1:0]            valid_o,
  input  logic [NumChan-1:0]            ready_i,
  output logic [NumChan*DataWidth-1:0]  data_o,
  output logic [NumChan*OccW-1:0]       count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [15:0]         lfsr_q;
  logic                lfsr_fb;
  logic [CntWidth-1:0] jit;
  logic [NumChan-1:0]  push_vec;

  // Fibonacci taps 16,14,13,11 in right-shift form
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign jit = JitterEn ? (lfsr_q[CntWidth-1:0] & jitter_mask_i)
                        : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LfsrSeed;
    end else if (|push_vec) begin
      lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
    end
  end

  for (genvar c = 0; c < NumChan; c++) begin : g_ch
    logic [DataWidth-1:0] mem [Depth];
    logic [CntWidth-1:0]  cd_q [Depth];
    logic [Depth-1:0]     occ_q;
    logic [PtrW-1:0]      wr_q;
    logic [PtrW-1:0]      rd_q;
    logic [OccW-1:0]      cnt_q;
    logic [CntWidth:0]    sum;
    logic [CntWidth-1:0]  eff;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 head_ok;

    assign sum = {1'b0, delay_i[c*CntWidth +: CntWidth]}
               + {1'b0, jit};
    assign eff = sum[CntWidth] ? '1 : sum[CntWidth-1:0];

    assign full    = (cnt_q == OccW'(Depth));
    assign empty   = (cnt_q == '0);
    assign push    = valid_i[c] & ~full;
    assign head_ok = ~empty & (cd_q[rd_q] == '0);
    assign pop     = head_ok & ready_i[c];

    assign push_vec[c] = push;
    assign ready_o[c]  = ~full;
    assign valid_o[c]  = head_ok;
    assign count_o[c*OccW +: OccW] = cnt_q;
    assign data_o[c*DataWidth +: DataWidth] =
      empty ? '0 : mem[rd_q];

    always_ff @(posedge clk_i) begin
      if (push) begin
        mem[wr_q] <= data_i[c*DataWidth +: DataWidth];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < Depth; i++) begin
          cd_q[i] <= '0;
        end
        occ_q <= '0;
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        // every waiting entry ages, head or not
        for (int i = 0; i < Depth; i++) begin
          if (occ_q[i] && cd_q[i] != '0) begin
            cd_q[i] <= cd_q[i] - 1'b1;
          end
        end
        if (pop) begin
          occ_q[rd_q] <= 1'b0;
          rd_q <= (rd_q == PtrW'(Depth - 1)) ? '0
                                             : rd_q + 1'b1;
        end
        if (push) begin
          cd_q[wr_q]  <= eff;
          occ_q[wr_q] <= 1'b1;
          wr_q <= (wr_q == PtrW'(Depth - 1)) ? '0
                                             : wr_q + 1'b1;
        end
        unique case ({push, pop})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_delay_multi.sv
// Randomized bench for stream_delay_multi against a queue model.
// A second instance with jitter enabled covers latency ranges.
module tb_stream_delay_multi;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [39:0]  delay_i;
  logic [7:0]   jitter_mask_i;
  logic [4:0]   valid_i;
  logic [4:0]   ready_o;
  logic [319:0] data_i;
  logic [4:0]   valid_o;
  logic [4:0]   ready_i;
  logic [319:0] data_o;
  logic [19:0]  count_o;

  logic [7:0]   j_delay;
  logic [7:0]   j_mask;
  logic [0:0]   j_valid;
  logic [0:0]   j_rdy;
  logic [15:0]  j_din;
  logic [0:0]   j_vout;
  logic [0:0]   j_rin;
  logic [15:0]  j_dout;
  logic [3:0]   j_count;

  always #5 clk_i = ~clk_i;

  stream_delay_multi u_dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .delay_i       (delay_i),
    .jitter_mask_i (jitter_mask_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .data_i        (data_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .data_o        (data_o),
    .count_o       (count_o)
  );

  stream_delay_multi #(
    .NumChan   (1),
    .DataWidth (16),
    .JitterEn  (1'b1)
  ) u_jit (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .delay_i       (j_delay),
    .jitter_mask_i (j_mask),
    .valid_i       (j_valid),
    .ready_o       (j_rdy),
    .data_i        (j_din),
    .valid_o       (j_vout),
    .ready_i       (j_rin),
    .data_o        (j_dout),
    .count_o       (j_count)
  );

  typedef struct {
    logic [63:0] d;
    int          rdy;
  } beat_t;

  beat_t       q [5][$];
  logic [63:0] din [5];
  logic [7:0]  dly [5];
  int          edge_n = 0;
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic rand_din();
    for (int c = 0; c < 5; c++) begin
      din[c] = {$urandom, $urandom};
    end
  endtask

  // One clock: drive, apply model rules, compare all outputs.
  task automatic step(input logic [4:0] v,
                      input logic [4:0] r);
    logic [4:0]  ev;
    logic [4:0]  er;
    logic [19:0] ec;
    valid_i = v;
    ready_i = r;
    for (int c = 0; c < 5; c++) begin
      data_i[c*64 +: 64] = din[c];
      delay_i[c*8 +: 8]  = dly[c];
    end
    @(posedge clk_i);
    edge_n++;
    for (int c = 0; c < 5; c++) begin
      bit    popf;
      bit    pushf;
      beat_t b;
      popf  = q[c].size() > 0 && r[c] &&
              q[c][0].rdy <= edge_n - 1;
      pushf = v[c] && q[c].size() < 8;
      if (popf) void'(q[c].pop_front());
      if (pushf) begin
        b.d   = din[c];
        b.rdy = edge_n + int'(dly[c]);
        q[c].push_back(b);
      end
    end
    #1;
    for (int c = 0; c < 5; c++) begin
      ev[c] = q[c].size() > 0 && q[c][0].rdy <= edge_n;
      er[c] = q[c].size() != 8;
      ec[c*4 +: 4] = 4'(q[c].size());
    end
    chk("valid_o", 64'(valid_o), 64'(ev));
    chk("ready_o", 64'(ready_o), 64'(er));
    chk("count_o", 64'(count_o), 64'(ec));
    for (int c = 0; c < 5; c++) begin
      if (ev[c]) chk("data_o", data_o[c*64 +: 64], q[c][0].d);
    end
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_valid"}, 64'(valid_o), 64'h0);
    chk({tag, "_ready"}, 64'(ready_o), 64'h1f);
    chk({tag, "_count"}, 64'(count_o), 64'h0);
    chk({tag, "_data"}, data_o[63:0], 64'h0);
  endtask

  task automatic jit_beat(input logic [7:0] d,
                          input logic [7:0] m,
                          output int lat);
    logic [15:0] dv;
    dv      = 16'($urandom);
    j_delay = d;
    j_mask  = m;
    j_din   = dv;
    j_valid = 1'b1;
    @(posedge clk_i);
    #1;
    j_valid = 1'b0;
    lat = -1;
    for (int e = 0; e < 300; e++) begin
      if (j_vout[0]) begin
        lat = e + 1;
        break;
      end
      @(posedge clk_i);
      #1;
    end
    if (lat < 0) chk("jit_timeout", 64'h0, 64'h1);
    else chk("jit_data", 64'(j_dout), 64'(dv));
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int lat;
    int lmin;
    int lmax;
    rst_ni        = 1'b0;
    delay_i       = '0;
    jitter_mask_i = '0;
    valid_i       = '0;
    ready_i       = '0;
    data_i        = '0;
    j_delay       = '0;
    j_mask        = '0;
    j_valid       = '0;
    j_din         = '0;
    j_rin         = 1'b1;
    for (int c = 0; c < 5; c++) dly[c] = '0;
    rand_din();
    #2;
    reset_chk("rst");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // fixed latency on ch0
    dly[0] = 8'd4;
    din[0] = 64'hDEAD;
    step(5'b00001, 5'h1f);
    for (int i = 0; i < 8; i++) step(5'b0, 5'h1f);

    // throughput on ch1
    dly[1] = 8'd3;
    for (int i = 0; i < 20; i++) begin
      rand_din();
      step(5'b00010, 5'h1f);
    end
    for (int i = 0; i < 6; i++) step(5'b0, 5'h1f);

    // fill ch2, then release
    dly[2] = 8'd0;
    for (int i = 0; i < 10; i++) begin
      rand_din();
      step(5'b00100, 5'h00);
    end
    chk("full_count", 64'(count_o[11:8]), 64'd8);
    chk("full_ready", 64'(ready_o[2]), 64'd0);
    for (int i = 0; i < 2; i++) begin
      rand_din();
      step(5'b00100, 5'h1f);
    end
    for (int i = 0; i < 12; i++) step(5'b0, 5'h1f);

    // head blocking on ch3 while ch4 streams
    dly[4] = 8'd2;
    dly[3] = 8'd9;
    rand_din();
    step(5'b11000, 5'h1f);
    dly[3] = 8'd0;
    rand_din();
    step(5'b11000, 5'h1f);
    for (int i = 0; i < 12; i++) begin
      rand_din();
      step(5'b10000, 5'h1f);
    end
    for (int i = 0; i < 6; i++) step(5'b0, 5'h1f);

    // reset with three beats in flight
    dly[0] = 8'd20;
    for (int i = 0; i < 3; i++) begin
      rand_din();
      step(5'b00001, 5'h1f);
    end
    chk("pre_rst_count", 64'(count_o[3:0]), 64'd3);
    rst_ni = 1'b0;
    #1;
    reset_chk("mid_rst");
    for (int c = 0; c < 5; c++) q[c].delete();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 25; i++) step(5'b0, 5'h1f);

    // random traffic with per-cycle delay changes
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 5; c++) dly[c] = 8'($urandom_range(0, 10));
      rand_din();
      step(5'($urandom), 5'($urandom));
    end
    for (int i = 0; i < 30; i++) step(5'b0, 5'h1f);

    // jittered latency window
    lmin = 1000;
    lmax = -1;
    for (int i = 0; i < 30; i++) begin
      jit_beat(8'd2, 8'h07, lat);
      chk("jit_range", 64'(lat >= 3 && lat <= 10), 64'd1);
      if (lat < lmin) lmin = lat;
      if (lat > lmax) lmax = lat;
    end
    chk("jit_spread", 64'(lmax > lmin), 64'd1);
    jit_beat(8'hFE, 8'hFF, lat);
    chk("jit_sat", 64'(lat >= 255 && lat <= 256), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
